// File: rtl/voxel_pkg.sv
// Shared types and constants for the voxel frame sequencer.
// Holds the FSM state enum, camera field layout and power-on camera.
package voxel_pkg;

  typedef enum logic [2:0] {
    S_BUILD,
    S_WAIT_WORLD,
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_ABORT
  } state_t;

  localparam int F_X       = 0;
  localparam int F_Y       = 1;
  localparam int F_Z       = 2;
  localparam int F_DIR_X   = 3;
  localparam int F_DIR_Y   = 4;
  localparam int F_DIR_Z   = 5;
  localparam int F_PLANE_X = 6;
  localparam int F_PLANE_Y = 7;
  localparam int NUM_FIELDS = 8;

  localparam int DEF_POS     = 10 << 8;
  localparam int DEF_DIR_X   = 256;
  localparam int DEF_PLANE_Y = 170;

  function automatic int field_default(input int f);
    case (f)
      F_X, F_Y, F_Z: return DEF_POS;
      F_DIR_X:       return DEF_DIR_X;
      F_PLANE_Y:     return DEF_PLANE_Y;
      default:       return 0;
    endcase
  endfunction

  // Packed default camera, field 0 in the LSBs; callers truncate.
  function automatic logic [511:0] def_cam(input int cam_w);
    logic [511:0] v;
    int fv;
    v = '0;
    for (int f = 0; f < NUM_FIELDS; f++) begin
      fv = field_default(f);
      for (int b = 0; b < cam_w && b < 32; b++) begin
        v[f*cam_w + b] = fv[b];
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/voxel_cam_bank.sv
// Shadow camera storage: one write port, one write-first read port.
// Out-of-range write indices are dropped.
module voxel_cam_bank
  import voxel_pkg::*;
#(
  parameter int NUM_VIEWS = 2,
  parameter int CAM_W     = 16,
  parameter int VW        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [VW-1:0]     wr_idx,
  input  logic [8*CAM_W-1:0] wr_data,
  input  logic [VW-1:0]     rd_idx,
  output logic [8*CAM_W-1:0] rd_data
);

  localparam int CW = 8 * CAM_W;
  localparam logic [CW-1:0] DEF_CAM = CW'(def_cam(CAM_W));

  logic [CW-1:0] mem [NUM_VIEWS];
  logic          wr_ok;

  assign wr_ok = wr_en && (int'(wr_idx) < NUM_VIEWS);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VIEWS; i++) begin
        mem[i] <= DEF_CAM;
      end
    end else if (wr_ok) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rd_data = mem[rd_idx];
    if (wr_ok && wr_idx == rd_idx) begin
      rd_data = wr_data;
    end
  end

endmodule

// File: rtl/voxel_frame_sequencer.sv
// Frame sequencer: world build, per-frame camera latch, raycaster
// launch, timeout abort and round-robin view selection.
module voxel_frame_sequencer
  import voxel_pkg::*;
#(
  parameter int NUM_VIEWS = 2,
  parameter int CAM_W     = 16,
  parameter int CNT_W     = 32,
  parameter int TIMEOUT   = 2000000,
  parameter int TEST_FORCE_WORLD_READY = 0,
  localparam int VW = (NUM_VIEWS > 1) ? $clog2(NUM_VIEWS) : 1,
  localparam int CW = 8 * CAM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_reset,
  input  logic [1:0]       mode,
  input  logic             start_req,
  output logic             world_start,
  input  logic             world_done,
  output logic             core_start,
  input  logic             core_busy,
  input  logic             core_done,
  output logic             core_abort,
  input  logic             cam_load,
  input  logic [VW-1:0]    cam_view,
  input  logic [CW-1:0]    cam_data_in,
  output logic [CW-1:0]    cam_active,
  output logic [VW-1:0]    view_idx,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_count,
  output logic             timeout_err,
  output logic             busy
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] DEF_CAM = CW'(def_cam(CAM_W));

  state_t        state;
  state_t        nxt;
  logic          clr;
  logic          pending;
  logic [VW-1:0] next_view;
  logic [TW-1:0] run_cnt;
  logic [CW-1:0] shadow;
  logic          launch;
  logic          done_hit;
  logic          to_hit;
  logic          can_launch;

  assign clr      = rst | soft_reset;
  assign launch   = (state == S_LAUNCH);
  assign done_hit = (state == S_RUN) && core_done;
  assign to_hit   = (state == S_RUN) && !core_done
                 && (run_cnt == TW'(TIMEOUT - 1));

  voxel_cam_bank #(
    .NUM_VIEWS (NUM_VIEWS),
    .CAM_W     (CAM_W),
    .VW        (VW)
  ) u_bank (
    .clk     (clk),
    .rst     (clr),
    .wr_en   (cam_load),
    .wr_idx  (cam_view),
    .wr_data (cam_data_in),
    .rd_idx  (next_view),
    .rd_data (shadow)
  );

  always_comb begin
    can_launch = 1'b0;
    unique case (1'b1)
      (mode == 2'd0): can_launch = !core_busy;
      (mode == 2'd1): can_launch = !core_busy && pending;
      default:        can_launch = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state <= S_BUILD;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_BUILD:
        nxt = (TEST_FORCE_WORLD_READY != 0) ? S_IDLE : S_WAIT_WORLD;
      S_WAIT_WORLD:
        if (world_done) nxt = S_IDLE;
      S_IDLE:
        if (can_launch) nxt = S_LAUNCH;
      S_LAUNCH:
        nxt = S_RUN;
      S_RUN:
        if (core_done)   nxt = S_IDLE;
        else if (to_hit) nxt = S_ABORT;
      S_ABORT:
        if (!core_busy) nxt = S_IDLE;
      default:
        nxt = S_BUILD;
    endcase
  end

  // Gated by reset so no pulse appears while reset is held.
  assign world_start = (state == S_BUILD) && (TEST_FORCE_WORLD_READY == 0)
                    && !clr;
  assign core_start  = launch;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (clr) begin
      pending     <= 1'b0;
      next_view   <= '0;
      view_idx    <= '0;
      cam_active  <= DEF_CAM;
      run_cnt     <= '0;
      frame_done  <= 1'b0;
      core_abort  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (start_req)   pending <= 1'b1;
      else if (launch) pending <= 1'b0;
      if (launch) begin
        cam_active <= shadow;
        view_idx   <= next_view;
        run_cnt    <= '0;
      end else if (state == S_RUN) begin
        run_cnt <= run_cnt + TW'(1);
      end
      frame_done <= done_hit;
      core_abort <= to_hit;
      if (to_hit) timeout_err <= 1'b1;
      if (done_hit) begin
        next_view <= (next_view == VW'(NUM_VIEWS - 1))
                   ? '0 : next_view + VW'(1);
      end
    end
  end

  // Survives soft_reset; only a full reset clears it.
  always_ff @(posedge clk) begin
    if (rst)                         frame_count <= '0;
    else if (done_hit && !soft_reset) frame_count <= frame_count + CNT_W'(1);
  end

endmodule
